// File: rtl/aes_pkg.sv
// Shared types and widths for the AES-128 decryption stream controller.
package aes_pkg;

   localparam int unsigned AES_BLK_W     = 128;
   localparam int unsigned AES_KEY_W     = 128;
   localparam int unsigned AES_BLK_BYTES = 16;
   localparam int unsigned AES_CNT_W     = $clog2(AES_BLK_BYTES);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with occupancy count; head is visible on rd_data_o.
module aes_blk_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr_en_i && (cnt_q != CNT_W'(DEPTH));
   assign rd_ok = rd_en_i && (cnt_q != '0);

   // Storage, pointers and occupancy; simultaneous write and pop leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_ok, rd_ok})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/aes_dec_stream_ctrl.sv
// Byte-stream feeder and credit-controlled collector around a pipelined AES-128 decrypt core.
module aes_dec_stream_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned LATENCY    = 11,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AES_KEY_W-1:0] key_in,
   input  logic                 key_load,
   output logic                 key_err,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid,
   output logic                 byte_ready,
   output logic [AES_BLK_W-1:0] core_data_in,
   output logic [AES_KEY_W-1:0] core_key,
   input  logic [AES_BLK_W-1:0] core_data_out,
   output logic [AES_BLK_W-1:0] blk_out,
   output logic                 blk_valid,
   input  logic                 blk_ready,
   output logic                 busy
);

   localparam int unsigned TAG_W  = LATENCY - 1;
   localparam int unsigned INF_W  = $clog2(LATENCY + 1);
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W  = ((INF_W > FCNT_W) ? INF_W : FCNT_W) + 1;

   state_e                 state_q, state_d;
   logic [AES_CNT_W-1:0]   cnt_q, cnt_d;
   logic [AES_BLK_W-1:0]   blk_q, blk_d;
   logic [AES_KEY_W-1:0]   key_q, key_d;
   logic [TAG_W-1:0]       tag_q, tag_d;
   logic [INF_W-1:0]       inflight_q, inflight_d;
   logic                   key_err_q, key_err_d;

   logic                   issue_c;
   logic                   retire_c;
   logic                   pop_c;
   logic                   credit_c;
   logic                   busy_c;
   logic [FCNT_W-1:0]      fifo_cnt;
   logic [AES_BLK_W-1:0]   fifo_head;

   // A block may only issue if every outstanding block is guaranteed a FIFO slot.
   assign credit_c = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH);
   assign retire_c = tag_q[TAG_W-1];
   assign pop_c    = (fifo_cnt != '0) && blk_ready;
   assign busy_c   = (cnt_q != '0) || (state_q == HOLD) ||
                     (inflight_q != '0) || (fifo_cnt != '0);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         cnt_q      <= '0;
         blk_q      <= '0;
         key_q      <= '0;
         tag_q      <= '0;
         inflight_q <= '0;
         key_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         blk_q      <= blk_d;
         key_q      <= key_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         key_err_q  <= key_err_d;
      end
   end

   // Next-state: byte packing in FILL, credit-gated issue in HOLD, guarded key load, tag tracking.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      blk_d      = blk_q;
      key_d      = key_q;
      key_err_d  = 1'b0;
      issue_c    = 1'b0;

      case (state_q)
         FILL: begin
            if (byte_valid) begin
               blk_d = {blk_q[AES_BLK_W-8-1:0], byte_in};
               cnt_d = cnt_q + AES_CNT_W'(1);
               if (cnt_q == AES_CNT_W'(AES_BLK_BYTES - 1)) state_d = HOLD;
            end
         end
         HOLD: begin
            if (credit_c) begin
               issue_c = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      // Key may only change when nothing is partially packed, held or in flight.
      if (key_load) begin
         if (!busy_c) key_d     = key_in;
         else         key_err_d = 1'b1;
      end

      tag_d      = TAG_W'({tag_q, issue_c});
      inflight_d = inflight_q + INF_W'(issue_c) - INF_W'(retire_c);
   end

   aes_blk_fifo #(
      .WIDTH (AES_BLK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (retire_c),
      .wr_data_i (core_data_out),
      .rd_en_i   (pop_c),
      .rd_data_o (fifo_head),
      .count_o   (fifo_cnt)
   );

   assign byte_ready   = (state_q == FILL);
   assign core_data_in = blk_q;
   assign core_key     = key_q;
   assign key_err      = key_err_q;
   assign blk_out      = fifo_head;
   assign blk_valid    = (fifo_cnt != '0);
   assign busy         = busy_c;

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Scoreboard bench for aes_dec_stream_ctrl with a behavioural pipelined core stand-in.
module tb_aes_dec_stream_ctrl;

   localparam int unsigned LAT = 11;
   localparam int unsigned FD  = 4;

   localparam logic [127:0] KAT_KEY = 128'h5468617473206d79204b756e67204675;
   localparam logic [127:0] KAT_CT  = 128'h29c3505f571420f6402299b31a02d73a;
   localparam logic [127:0] KAT_PT  = 128'h54776f204f6e65204e696e652054776f;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] key_in;
   logic         key_load;
   logic         key_err;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         byte_ready;
   logic [127:0] core_data_in;
   logic [127:0] core_key;
   logic [127:0] core_data_out;
   logic [127:0] blk_out;
   logic         blk_valid;
   logic         blk_ready;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_pops   = 0;
   int mdl_cnt  = 0;
   logic [127:0] mdl_blk = '0;
   logic [127:0] exp_key = '0;
   logic [127:0] exp_q[$];
   int           pop_cyc[$];
   logic [127:0] core_pipe [LAT-1];
   bit           rnd_on = 1'b0;

   aes_dec_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_in        (key_in),
      .key_load      (key_load),
      .key_err       (key_err),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .core_data_in  (core_data_in),
      .core_key      (core_key),
      .core_data_out (core_data_out),
      .blk_out       (blk_out),
      .blk_valid     (blk_valid),
      .blk_ready     (blk_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core stand-in: the known vector decrypts to its known plaintext, anything else to a keyed scramble.
   function automatic logic [127:0] mock_dec(input logic [127:0] ct, input logic [127:0] k);
      if (ct == KAT_CT && k == KAT_KEY) return KAT_PT;
      return ct ^ {k[63:0], k[127:64]} ^ 128'hA5A5_0F0F_3C3C_9696_A5A5_0F0F_3C3C_9696;
   endfunction

   // Pipelined core: input sampled each edge, result presented after the register chain.
   always @(posedge clk) begin
      core_pipe[0] <= mock_dec(core_data_in, core_key);
      for (int i = 1; i < int'(LAT) - 1; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_data_out = core_pipe[LAT-2];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: expected plaintext pushed when a 16th byte is accepted, compared on every pop.
   always @(negedge clk) begin
      if (rst_n) begin
         if (byte_valid && byte_ready) begin
            mdl_blk = {mdl_blk[119:0], byte_in};
            mdl_cnt++;
            if (mdl_cnt == 16) begin
               exp_q.push_back(mock_dec(mdl_blk, exp_key));
               mdl_cnt = 0;
            end
         end
         if (blk_valid && blk_ready) begin
            n_pops++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_blk", 1, 0);
            else                   check("blk_out", blk_out, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  n   = 0;
      bit  acc = 1'b0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = byte_ready;
         tick();
         n++;
      end
      byte_valid = 1'b0;
      if (!acc) check("byte_timeout", 0, 1);
   endtask

   task automatic send_block(input logic [127:0] ct, input bit gaps);
      for (int k = 0; k < 16; k++) begin
         int g = 0;
         while (gaps && g < 8 && $urandom_range(0, 1) == 1) begin
            tick();
            g++;
         end
         send_byte(ct[127-8*k -: 8]);
      end
   endtask

   task automatic load_key(input logic [127:0] k, input bit expect_ok);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      if (expect_ok) exp_key = k;
      check("key_err", key_err, !expect_ok);
      tick();
      check("key_err_pulse", key_err, 0);
      check("core_key", core_key, exp_key);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         tick();
         n++;
      end
      check(tag, (exp_q.size() == 0 && !busy), 1);
   endtask

   function automatic logic [127:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      int n;
      int pops0;
      logic [127:0] head0;

      rst_n = 1'b0; key_in = '0; key_load = 1'b0;
      byte_in = '0; byte_valid = 1'b0; blk_ready = 1'b0;
      repeat (3) tick();

      // Reset values.
      check("rst_byte_ready", byte_ready, 1);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_key_err", key_err, 0);
      check("rst_busy", busy, 0);
      check("rst_blk_out", blk_out, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_data_in", core_data_in, 0);
      rst_n = 1'b1;
      tick();

      // Known-answer block and issue-to-output latency.
      load_key(KAT_KEY, 1'b1);
      send_block(KAT_CT, 1'b0);
      check("hold_byte_ready", byte_ready, 0);
      check("hold_busy", busy, 1);
      n = 0;
      while (!blk_valid && n < 100) begin
         tick();
         n++;
      end
      check("kat_latency", n, LAT);
      check("kat_blk_out", blk_out, KAT_PT);
      blk_ready = 1'b1;
      wait_drain("kat_drain");

      // Four back-to-back blocks at full throughput.
      pop_cyc.delete();
      pops0 = n_pops;
      for (int b = 0; b < 4; b++) send_block(rand_blk(), 1'b0);
      wait_drain("b2b_drain");
      check("b2b_pops", n_pops - pops0, 4);
      for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
         check("b2b_spacing", pop_cyc[i] - pop_cyc[i-1], 17);
      tick();
      check("b2b_busy_low", busy, 0);

      // Backpressure: six blocks against a stalled consumer.
      blk_ready = 1'b0;
      pops0 = n_pops;
      fork
         begin
            for (int b = 0; b < 6; b++) send_block(rand_blk(), 1'b0);
         end
         begin
            repeat (150) tick();
            check("bp_byte_ready", byte_ready, 0);
            check("bp_blk_valid", blk_valid, 1);
            check("bp_accepted", exp_q.size(), 5);
            head0 = exp_q[0];
            check("bp_head", blk_out, head0);
            repeat (5) tick();
            check("bp_head_stable", blk_out, head0);
            blk_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_pops", n_pops - pops0, 6);

      // Rejected key load in the middle of a block.
      for (int k = 0; k < 5; k++) send_byte(KAT_CT[127-8*k -: 8]);
      load_key(128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1'b0);
      for (int k = 5; k < 16; k++) send_byte(KAT_CT[127-8*k -: 8]);
      n = 0;
      while (!blk_valid && n < 100) begin
         tick();
         n++;
      end
      check("keyerr_blk_out", blk_out, KAT_PT);
      wait_drain("keyerr_drain");

      // Reset with blocks in the FIFO and one in flight.
      blk_ready = 1'b0;
      for (int b = 0; b < 3; b++) send_block(rand_blk(), 1'b0);
      repeat (2) tick();
      check("prerst_blk_valid", blk_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_blk_valid", blk_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_byte_ready", byte_ready, 1);
      exp_q.delete();
      mdl_cnt = 0;
      exp_key = '0;
      tick();
      rst_n = 1'b1;
      blk_ready = 1'b1;
      repeat (20) tick();
      check("postrst_no_stale", blk_valid, 0);
      load_key(KAT_KEY, 1'b1);
      pops0 = n_pops;
      send_block(KAT_CT, 1'b0);
      wait_drain("postrst_drain");
      check("postrst_pops", n_pops - pops0, 1);

      // Random byte gaps and random consumer readiness over 40 blocks.
      load_key(rand_blk(), 1'b1);
      pops0 = n_pops;
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               tick();
               blk_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int b = 0; b < 40; b++) send_block(rand_blk(), 1'b1);
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      blk_ready = 1'b1;
      wait_drain("rnd_drain");
      check("rnd_pops", n_pops - pops0, 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
